mux_bus_loader: RTL and testbench

- Sequential staging block that sits directly upstream of the ALU's width/channel multiplexer.
- Accepts WIDTH-bit words one per handshake and packs CHANNELS of them into a CHANNELS*WIDTH bus. It then presents that bus plus a registered channel select to the mux until the consumer acknowledges.
- Decouples serial operand/result production from the mux's parallel bus input.

---
 rtl/mux_bus_loader.sv | 112 +++++++++++
 tb/tb_mux_bus_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_loader.sv
// mux_bus_loader: packs CHANNELS serial words into one bus for the ALU mux.
// Optional synchronous flush input when MUX_BUS_LOADER_FLUSH_EN is defined.
module mux_bus_loader #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int SEL_LENGTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef MUX_BUS_LOADER_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_word,
    input  logic [SEL_LENGTH-1:0]     in_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_bus,
    output logic [SEL_LENGTH-1:0]     out_sel,
    output logic [SEL_LENGTH-1:0]     wptr
);

    typedef enum logic {
        LOAD    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [SEL_LENGTH-1:0] LAST = SEL_LENGTH'(CHANNELS - 1);

    if (CHANNELS < 2 || CHANNELS > (1 << SEL_LENGTH)) begin : g_bad_cfg
        $fatal(1, "mux_bus_loader: CHANNELS must be in 2..2**SEL_LENGTH");
    end

    state_t state;
    state_t state_next;
    logic   load_xfer;
    logic   last_word;
    logic   flush_req;

`ifdef MUX_BUS_LOADER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // The write pointer only ever reaches CHANNELS-1, so this is the wrap point.
    assign last_word = (wptr == LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; flush overrides every handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_xfer  = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready  = 1'b1;
                load_xfer = in_valid;
                if (in_valid && last_word) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
        if (flush_req) begin
            state_next = LOAD;
            load_xfer  = 1'b0;
        end
    end

    // Frame storage, write pointer and select capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            out_bus <= '0;
            out_sel <= '0;
        end else if (flush_req) begin
            wptr <= '0;
        end else if (load_xfer) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wptr == SEL_LENGTH'(k)) begin
                    out_bus[k*WIDTH +: WIDTH] <= in_word;
                end
            end
            if (last_word) begin
                wptr    <= '0;
                out_sel <= in_sel;
            end else begin
                wptr <= wptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_bus_loader.sv
// Directed self-checking bench for mux_bus_loader (4- and 3-channel builds).
// Exercises the flush path too when MUX_BUS_LOADER_FLUSH_EN is defined.
module tb_mux_bus_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_word;
    logic [1:0]  in_sel, out_sel, wptr;
    logic [31:0] out_bus;
`ifdef MUX_BUS_LOADER_FLUSH_EN
    logic        flush;
`endif

    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [7:0]  in_word3;
    logic [1:0]  in_sel3, out_sel3, wptr3;
    logic [23:0] out_bus3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_bus_loader #(.WIDTH(8), .CHANNELS(4), .SEL_LENGTH(2)) dut (
        .clk(clk), .reset(reset),
`ifdef MUX_BUS_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_bus(out_bus), .out_sel(out_sel), .wptr(wptr)
    );

    mux_bus_loader #(.WIDTH(8), .CHANNELS(3), .SEL_LENGTH(2)) dut3 (
        .clk(clk), .reset(reset),
`ifdef MUX_BUS_LOADER_FLUSH_EN
        .flush(1'b0),
`endif
        .in_valid(in_valid3), .in_ready(in_ready3), .in_word(in_word3),
        .in_sel(in_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_bus(out_bus3), .out_sel(out_sel3), .wptr(wptr3)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic [1:0] s);
        in_valid = 1'b1;
        in_word  = w;
        in_sel   = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_word = 0; in_sel = 0; out_ready = 0;
        in_valid3 = 0; in_word3 = 0; in_sel3 = 0; out_ready3 = 0;
`ifdef MUX_BUS_LOADER_FLUSH_EN
        flush = 0;
`endif
        step();
        step();
        reset = 1'b0;
        step();

        // reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_wptr", wptr, 0);
        check("rst_out_bus", out_bus, 0);
        check("rst_out_sel", out_sel, 0);

        // back-to-back frame
        send(8'h11, 0);
        check("b2b_wptr1", wptr, 1);
        send(8'h22, 0);
        send(8'h33, 0);
        check("b2b_wptr3", wptr, 3);
        check("b2b_not_early", out_valid, 0);
        send(8'h44, 2);
        check("b2b_out_valid", out_valid, 1);
        check("b2b_out_bus", out_bus, 32'h44332211);
        check("b2b_out_sel", out_sel, 2);
        check("b2b_in_ready", in_ready, 0);
        check("b2b_wptr_wrap", wptr, 0);

        // backpressure with in_valid held high
        in_valid = 1'b1;
        in_word  = 8'hFF;
        in_sel   = 1;
        for (int i = 0; i < 10; i++) step();
        check("bp_out_bus", out_bus, 32'h44332211);
        check("bp_in_ready", in_ready, 0);
        check("bp_wptr", wptr, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_sel", out_sel, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ack_in_ready", in_ready, 1);
        check("ack_out_valid", out_valid, 0);

        // frame with a 3-cycle gap; stale upper bytes visible after word 0
        send(8'h55, 0);
        check("gap_ch0_first", out_bus, 32'h44332255);
        send(8'h66, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("gap_wptr_hold", wptr, 2);
        end
        send(8'h77, 0);
        check("gap_not_early", out_valid, 0);
        send(8'h88, 1);
        check("gap_out_valid", out_valid, 1);
        check("gap_out_bus", out_bus, 32'h88776655);
        check("gap_out_sel", out_sel, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // asynchronous reset mid-frame
        send(8'hA0, 0);
        send(8'hA1, 0);
        check("ar_wptr_pre", wptr, 2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_wptr", wptr, 0);
        check("ar_out_bus", out_bus, 0);
        check("ar_in_ready", in_ready, 1);
        step();
        reset = 1'b0;
        step();
        send(8'hA0, 0);
        send(8'hA1, 0);
        send(8'hA2, 0);
        send(8'hA3, 3);
        check("ar_frame_bus", out_bus, 32'hA3A2A1A0);
        check("ar_frame_sel", out_sel, 3);
        check("ar_frame_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

`ifdef MUX_BUS_LOADER_FLUSH_EN
        // flush after 3 words; the 4th word offered with flush is dropped
        send(8'hB0, 0);
        send(8'hB1, 0);
        send(8'hB2, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 8'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_wptr", wptr, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_bus_kept", out_bus, 32'hA3B2B1B0);
        send(8'hC0, 0);
        send(8'hC1, 0);
        send(8'hC2, 0);
        check("fl_not_early", out_valid, 0);
        send(8'hC3, 1);
        check("fl_valid", out_valid, 1);
        check("fl_new_bus", out_bus, 32'hC3C2C1C0);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("fl_pres_valid", out_valid, 0);
        check("fl_pres_ready", in_ready, 1);
        check("fl_pres_wptr", wptr, 0);
        check("fl_pres_bus", out_bus, 32'hC3C2C1C0);
        check("fl_pres_sel", out_sel, 1);
`endif

        // 3-channel build, continuous streaming, out-of-range select
        out_ready3 = 1'b1;
        in_sel3    = 2'd3;
        check("c3_rst_wptr", wptr3, 0);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 3; c++) begin
                in_valid3 = 1'b1;
                in_word3  = 8'(f * 16 + c);
                step();
                check("c3_wptr", wptr3, (c + 1) % 3);
                check("c3_valid", out_valid3, c == 2);
            end
            check("c3_bus", out_bus3,
                  {8'(f * 16 + 2), 8'(f * 16 + 1), 8'(f * 16)});
            check("c3_sel", out_sel3, 3);
            in_word3 = 8'hEE;
            step();
            check("c3_pres_wptr", wptr3, 0);
            check("c3_pres_valid", out_valid3, 0);
            check("c3_pres_ready", in_ready3, 1);
        end
        in_valid3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
